// File: rtl/mul_sequencer.sv
// Multiply sequencer for the EX stage: latches operands, handshakes with the
// shared multiplier, counts its fixed latency, stalls the pipeline until the
// product lands, and owns the architectural HI/LO registers.
//
// state | meaning
// IDLE  | no multiply in flight; MTHI/MTLO writes accepted
// REQ   | operands latched, MulReq held until MulAck
// WAIT  | multiplier busy, counter runs down to the product cycle
// DONE  | product captured, ResultValid pulse, pipeline released
module mul_sequencer #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4
) (
  input  logic               Clock,
  input  logic               nReset,
  input  logic               Start,
  input  logic               Signed,
  input  logic               OpMull,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               Flush,
  input  logic               HiWe,
  input  logic               LoWe,
  input  logic [WIDTH-1:0]   WrData,
  output logic               MulReq,
  input  logic               MulAck,
  output logic [WIDTH-1:0]   MulA,
  output logic [WIDTH-1:0]   MulB,
  output logic               MulSigned,
  input  logic [2*WIDTH-1:0] MulP,
  output logic [WIDTH-1:0]   Hi,
  output logic [WIDTH-1:0]   Lo,
  output logic [WIDTH-1:0]   Result,
  output logic               ResultValid,
  output logic               nStall
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  localparam logic [3:0] CntLoad = 4'(LATENCY - 1);

  state_t     state;
  state_t     nextState;
  logic [3:0] counter;
  logic       opMull;
  logic       load;
  logic       capture;
  logic       ackTake;
  logic       stallReq;
  logic       idleWrite;

  // Next-state and handshake/stall decode; Flush overrides everything.
  always_comb begin
    nextState   = state;
    MulReq      = 1'b0;
    stallReq    = 1'b0;
    ResultValid = 1'b0;
    load        = 1'b0;
    capture     = 1'b0;
    ackTake     = 1'b0;
    case (state)
      IDLE: begin
        if (Start) begin
          load      = 1'b1;
          stallReq  = 1'b1;
          nextState = REQ;
        end
      end
      REQ: begin
        MulReq   = 1'b1;
        stallReq = 1'b1;
        if (MulAck) begin
          ackTake   = 1'b1;
          nextState = WAIT;
        end
      end
      WAIT: begin
        stallReq = 1'b1;
        if (counter == 4'd0) begin
          capture   = 1'b1;
          nextState = DONE;
        end
      end
      DONE: begin
        ResultValid = 1'b1;
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase
    if (Flush) begin
      nextState   = IDLE;
      MulReq      = 1'b0;
      stallReq    = 1'b0;
      ResultValid = 1'b0;
      load        = 1'b0;
      capture     = 1'b0;
      ackTake     = 1'b0;
    end
  end

  // MTHI/MTLO only land in IDLE when no multiply is being accepted.
  assign idleWrite = (state == IDLE) && !Start && !Flush;

  // Reset forces the pipeline free even if Start is still asserted.
  assign nStall = !stallReq || !nReset;

  // State register and latency down-counter.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      counter <= 4'd0;
    end else begin
      state <= nextState;
      if (ackTake) begin
        counter <= CntLoad;
      end else if ((state == WAIT) && (counter != 4'd0) && !Flush) begin
        counter <= counter - 4'd1;
      end
    end
  end

  // Operand latch, HI/LO/Result updates.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      MulA      <= '0;
      MulB      <= '0;
      MulSigned <= 1'b0;
      opMull    <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      Result    <= '0;
    end else begin
      if (load) begin
        MulA      <= A;
        MulB      <= B;
        MulSigned <= Signed;
        opMull    <= OpMull;
      end
      if (idleWrite && HiWe) begin
        Hi <= WrData;
      end
      if (idleWrite && LoWe) begin
        Lo <= WrData;
      end
      if (capture) begin
        Result <= MulP[WIDTH-1:0];
        if (!opMull) begin
          Hi <= MulP[2*WIDTH-1:WIDTH];
          Lo <= MulP[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: doc/mul_sequencer.md
Name: mul_sequencer

Overview:
Sequences the shared multi-cycle 32x32 multiplier for multiply-class instructions (MULT, MULTU, MULL) in the EX stage.
- Captures operands when a multiply reaches EX.
- Requests the multiplier through a req/ack handshake.
- Counts the fixed multiplier latency.
- Holds the pipeline via nStall until the product is ready.
- Owns the architectural HI/LO registers, including MTHI/MTLO writes.
- Its nStall is ANDed with the hazard unit's nStall at the pipeline-register enables.

Parameters:
WIDTH, 32, operand width; the product is 2*WIDTH.
LATENCY, 4, multiplier cycles from accepted request to valid MulP; legal range 1..15.

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
nReset  input  1  asynchronous active-low reset.
Start  input  1  valid multiply instruction in EX (MULT/MULTU/MULL decoded).
Signed  input  1  1 = signed operands (MULT/MULL), 0 = unsigned (MULTU).
OpMull  input  1  1 = MULL: result goes to the GPR only; HI/LO are unchanged.
A  input  WIDTH  Rs operand.
B  input  WIDTH  Rt operand.
Flush  input  1  synchronous kill of the EX instruction (branch/exception).
HiWe  input  1  MTHI write enable.
LoWe  input  1  MTLO write enable.
WrData  input  WIDTH  MTHI/MTLO data.
MulReq  output  1  request to the shared multiplier.
MulAck  input  1  multiplier accepted the request this cycle.
MulA  output  WIDTH  latched operand A.
MulB  output  WIDTH  latched operand B.
MulSigned  output  1  latched Signed.
MulP  input  2*WIDTH  product, valid LATENCY cycles after the ack cycle.
Hi  output  WIDTH  HI register.
Lo  output  WIDTH  LO register.
Result  output  WIDTH  MULL result (low word), held until the next capture.
ResultValid  output  1  one-cycle pulse when Result/HI/LO are updated.
nStall  output  1  0 = freeze PC/IF/ID/EX.

Behaviour:
- Reset (async, nReset=0), all outputs and state cleared:
  - state=IDLE, nStall=1, MulReq=0.
  - MulA, MulB, MulSigned, Hi, Lo, Result = 0; ResultValid=0; counter=0.
- Reset asserted mid-operation aborts immediately. HI/LO return to 0.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If Start && !Flush: latch A, B, Signed, OpMull; go to REQ.
  - Otherwise, HiWe writes Hi<=WrData and LoWe writes Lo<=WrData. Both may write in the same cycle.
  - HiWe/LoWe are ignored when Start=1; Start has priority.
- REQ:
  - MulReq=1 and is held stable until MulAck.
  - On MulAck: counter<=LATENCY-1, go to WAIT.
  - Unlimited ack delay is legal.
- WAIT:
  - If counter==0: capture MulP, go to DONE.
    - Result<=MulP[WIDTH-1:0].
    - If !OpMull: Hi<=MulP[2W-1:W], Lo<=MulP[W-1:0].
  - Else counter decrements.
- DONE:
  - ResultValid=1 and nStall=1; go to IDLE next cycle.
  - Start is ignored here, since it is the same, now-completing instruction.
- nStall (combinational):
  - 0 when (IDLE && Start && !Flush), or in REQ, or in WAIT; 1 otherwise.
  - Stall length with immediate ack = LATENCY+2 cycles (default 6).
- Flush, in any state:
  - Next state IDLE.
  - MulReq drops in the same cycle (combinational gate).
  - No HI/LO/Result update; ResultValid=0; nStall=1 in the flush cycle.
- MulAck coincident with Flush in REQ: the ack is consumed and the product is discarded. The multiplier result is not tracked further.
- MulAck is ignored outside REQ.
- HiWe/LoWe outside IDLE cannot occur architecturally (the pipeline is stalled); they are ignored.
- The sequencer performs no arithmetic; product sign handling belongs to the multiplier via MulSigned.

Test Plan:
1. Reset, then Start MULT with A=0xFFFFFFFF, B=0x00000002, Signed=1, MulAck in the REQ cycle.
   -> nStall low for exactly 6 cycles.
   -> ResultValid pulses once; Hi=0xFFFFFFFF, Lo=0xFFFFFFFE.
2. Same operands with Signed=0 (MULTU).
   -> Hi=0x00000001, Lo=0xFFFFFFFE, MulSigned=0 during REQ.
3. Preload HI=0x1234 and LO=0x5678 via HiWe/LoWe. Then MULL with A=7, B=6.
   -> Result=42, ResultValid pulses, Hi/Lo remain 0x1234/0x5678.
4. Start, then hold MulAck low for 5 cycles.
   -> MulReq stays high with MulA/MulB stable.
   -> nStall stays low for 5+LATENCY+2=11 cycles total.
5. Start, then Flush during WAIT.
   -> Next cycle IDLE, nStall=1, no ResultValid, Hi/Lo unchanged.
   -> A following Start is accepted normally.
6. Assert nReset low during WAIT.
   -> All outputs are at reset values immediately, before the next clock edge.
   -> After release, a MULT with A=3, B=5 completes with Lo=15, Hi=0.
